// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter: registered one-hot active-low GNT_, bus parking,
// revocation of unused grants and pre-emption of the owner when others wait.
module pci_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int PARK_MASTER = 0,
  parameter int GNT_TIMEOUT = 16,
  localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int TW = $clog2(GNT_TIMEOUT)
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic [NUM_MASTERS-1:0] REQ_,
  input  logic                   FRAME_,
  input  logic                   IRDY_,
  output logic [NUM_MASTERS-1:0] GNT_,
  output logic [OW-1:0]          owner,
  output logic                   owner_vld,
  output logic                   timeout_err,
  output logic [1:0]             state_dbg
);

  // Handshake: a master requests by holding REQ_[i] low; it may start a
  // transaction (FRAME_ low) only on a bus-idle edge where its GNT_ is low.
  // GNT_ is withdrawn once the master stops requesting, never uses it, or
  // another master is waiting; a started transaction always runs to bus idle.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PARKED  = 2'd1,
    S_GRANTED = 2'd2,
    S_BUSY    = 2'd3
  } state_t;

  localparam logic [NUM_MASTERS-1:0] ONE       = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [NUM_MASTERS-1:0] PARK_MASK = ONE << PARK_MASTER;
  localparam logic [OW-1:0]          PARK_IDX  = OW'(PARK_MASTER);
  localparam logic [OW-1:0]          LAST_IDX  = OW'(NUM_MASTERS - 1);
  localparam logic [TW-1:0]          TCNT_MAX  = TW'(GNT_TIMEOUT - 1);

  state_t                   state, state_nxt;
  logic [NUM_MASTERS-1:0]   gnt_nxt;
  logic [OW-1:0]            owner_nxt, rr_ptr, rr_nxt, winner, cand;
  logic                     vld_nxt, terr_nxt, found;
  logic [TW-1:0]            tcnt, tcnt_nxt;
  logic                     bus_idle, any_req, other_req, nonpark_req;
  logic [NUM_MASTERS-1:0]   owner_mask;

  assign bus_idle    = FRAME_ & IRDY_;
  assign any_req     = ~&REQ_;
  assign owner_mask  = ONE << owner;
  assign other_req   = |(~REQ_ & ~owner_mask);
  assign nonpark_req = |(~REQ_ & ~PARK_MASK);
  assign state_dbg   = state;

  // First requester strictly after rr_ptr, wrapping at NUM_MASTERS.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = OW'((int'(rr_ptr) + k) % NUM_MASTERS);
      if (!found && !REQ_[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = GNT_;
    owner_nxt = owner;
    vld_nxt   = owner_vld;
    terr_nxt  = 1'b0;
    rr_nxt    = rr_ptr;
    tcnt_nxt  = tcnt;
    case (state)
      S_IDLE: begin
        gnt_nxt = '1;
        vld_nxt = 1'b0;
        if (bus_idle) begin
          vld_nxt = 1'b1;
          if (any_req) begin
            state_nxt = S_GRANTED;
            gnt_nxt   = ~(ONE << winner);
            owner_nxt = winner;
            tcnt_nxt  = '0;
          end else begin
            state_nxt = S_PARKED;
            gnt_nxt   = ~PARK_MASK;
            owner_nxt = PARK_IDX;
          end
        end
      end
      S_PARKED: begin
        if (!FRAME_) begin
          state_nxt = S_BUSY;
          rr_nxt    = PARK_IDX;
        end else if (nonpark_req) begin
          state_nxt = S_IDLE;
          gnt_nxt   = '1;
          vld_nxt   = 1'b0;
        end
      end
      S_GRANTED: begin
        if (!FRAME_) begin
          state_nxt = S_BUSY;
          rr_nxt    = owner;
        end else if (REQ_[owner]) begin
          state_nxt = S_IDLE;
          gnt_nxt   = '1;
          vld_nxt   = 1'b0;
        end else if (tcnt == TCNT_MAX) begin
          state_nxt = S_IDLE;
          gnt_nxt   = '1;
          vld_nxt   = 1'b0;
          terr_nxt  = 1'b1;
          rr_nxt    = owner;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      S_BUSY: begin
        if (bus_idle) begin
          state_nxt = S_IDLE;
          gnt_nxt   = '1;
          vld_nxt   = 1'b0;
        end else if (REQ_[owner] || other_req) begin
          // Once withdrawn the grant stays off until the bus returns idle.
          gnt_nxt = '1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state       <= S_IDLE;
      GNT_        <= '1;
      owner       <= '0;
      owner_vld   <= 1'b0;
      timeout_err <= 1'b0;
      rr_ptr      <= LAST_IDX;
      tcnt        <= '0;
    end else begin
      state       <= state_nxt;
      GNT_        <= gnt_nxt;
      owner       <= owner_nxt;
      owner_vld   <= vld_nxt;
      timeout_err <= terr_nxt;
      rr_ptr      <= rr_nxt;
      tcnt        <= tcnt_nxt;
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Bench for pci_bus_arbiter: vector table, directed multi-cycle sequences,
// and randomized traffic against an abstract ownership model.
module tb_pci_bus_arbiter;

  localparam int N    = 4;
  localparam int PARK = 0;
  localparam int TMO  = 16;

  localparam int MD_TURN  = 0;
  localparam int MD_PARK  = 1;
  localparam int MD_GRANT = 2;
  localparam int MD_BUSY  = 3;

  logic         clk;
  logic         reset_;
  logic [N-1:0] req_;
  logic         frame_;
  logic         irdy_;
  logic [N-1:0] gnt_;
  logic [1:0]   owner;
  logic         owner_vld;
  logic         timeout_err;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  pci_bus_arbiter #(
    .NUM_MASTERS(N),
    .PARK_MASTER(PARK),
    .GNT_TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .reset_     (reset_),
    .REQ_       (req_),
    .FRAME_     (frame_),
    .IRDY_      (irdy_),
    .GNT_       (gnt_),
    .owner      (owner),
    .owner_vld  (owner_vld),
    .timeout_err(timeout_err),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic         rst_n;
    logic [N-1:0] req;
    logic         frame;
    logic         irdy;
    logic [N-1:0] gnt;
    logic [1:0]   own;
    logic         vld;
    logic         terr;
  } vec_t;

  vec_t vecs[$];

  // driver tasks
  task automatic drive(input logic r, input logic [N-1:0] q, input logic f, input logic i);
    reset_ = r;
    req_   = q;
    frame_ = f;
    irdy_  = i;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (state %0d, t=%0t)", name, act, exp, state_dbg, $time);
    end
  endtask

  task automatic add_vec(input logic r, input logic [N-1:0] q, input logic f, input logic i,
                         input logic [N-1:0] g, input logic [1:0] o, input logic v, input logic t);
    vec_t e;
    e.rst_n = r; e.req = q; e.frame = f; e.irdy = i;
    e.gnt = g; e.own = o; e.vld = v; e.terr = t;
    vecs.push_back(e);
  endtask

  // abstract model: who holds the grant, whether it is live, how long unused
  int   m_mode, m_owner, m_age, m_last;
  bit   m_live, m_vld, m_terr;
  logic [N-1:0] exp_gnt;

  function automatic int pick(input logic [N-1:0] q, input int last);
    for (int k = 1; k <= N; k++)
      if (q[(last + k) % N] == 1'b0) return (last + k) % N;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = MD_TURN; m_owner = 0; m_age = 0; m_last = N - 1;
    m_live = 0; m_vld = 0; m_terr = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] q, input logic f, input logic i);
    bit idle;
    int others;
    logic [N-1:0] only_owner;
    idle   = f && i;
    m_terr = 0;
    others = 0;
    for (int k = 0; k < N; k++) if (k != PARK && q[k] == 1'b0) others++;
    case (m_mode)
      MD_TURN: if (idle) begin
        m_vld = 1; m_live = 1;
        if (q != '1) begin m_owner = pick(q, m_last); m_mode = MD_GRANT; m_age = 1; end
        else begin m_owner = PARK; m_mode = MD_PARK; end
      end
      MD_PARK: begin
        if (!f) begin m_mode = MD_BUSY; m_last = PARK; end
        else if (others > 0) begin m_mode = MD_TURN; m_live = 0; m_vld = 0; end
      end
      MD_GRANT: begin
        if (!f) begin m_mode = MD_BUSY; m_last = m_owner; end
        else if (q[m_owner]) begin m_mode = MD_TURN; m_live = 0; m_vld = 0; end
        else if (m_age == TMO) begin
          m_mode = MD_TURN; m_live = 0; m_vld = 0; m_terr = 1; m_last = m_owner;
        end else m_age++;
      end
      default: begin
        only_owner = ~(4'b0001 << m_owner);
        if (idle) begin m_mode = MD_TURN; m_live = 0; m_vld = 0; end
        else if (q != only_owner) m_live = 0;
      end
    endcase
    exp_gnt = m_live ? ~(4'b0001 << m_owner) : 4'b1111;
  endtask

  initial begin
    logic [N-1:0] rq;
    logic fr, ir;
    drive(1'b0, 4'b1111, 1'b1, 1'b1);

    // reset, park, grant master 2, round robin, parked pre-emption
    add_vec(0, 4'b1111, 1, 1, 4'b1111, 0, 0, 0);
    add_vec(0, 4'b1111, 1, 1, 4'b1111, 0, 0, 0);
    add_vec(0, 4'b1111, 1, 1, 4'b1111, 0, 0, 0);
    add_vec(1, 4'b1111, 1, 1, 4'b1110, 0, 1, 0);
    add_vec(1, 4'b1111, 1, 1, 4'b1110, 0, 1, 0);
    add_vec(1, 4'b1011, 1, 1, 4'b1111, 0, 0, 0);
    add_vec(1, 4'b1011, 1, 1, 4'b1011, 2, 1, 0);
    add_vec(1, 4'b1011, 0, 1, 4'b1011, 2, 1, 0);
    add_vec(1, 4'b1011, 0, 0, 4'b1011, 2, 1, 0);
    add_vec(1, 4'b1011, 1, 0, 4'b1011, 2, 1, 0);
    add_vec(1, 4'b1111, 1, 1, 4'b1111, 0, 0, 0);
    add_vec(1, 4'b0110, 1, 1, 4'b0111, 3, 1, 0);
    add_vec(1, 4'b0110, 0, 1, 4'b0111, 3, 1, 0);
    add_vec(1, 4'b0110, 0, 0, 4'b1111, 3, 1, 0);
    add_vec(1, 4'b0110, 1, 1, 4'b1111, 0, 0, 0);
    add_vec(1, 4'b0110, 1, 1, 4'b1110, 0, 1, 0);
    add_vec(1, 4'b1111, 1, 1, 4'b1111, 0, 0, 0);
    add_vec(1, 4'b1111, 1, 1, 4'b1110, 0, 1, 0);
    add_vec(1, 4'b1101, 0, 1, 4'b1110, 0, 1, 0);
    add_vec(1, 4'b1101, 0, 0, 4'b1111, 0, 1, 0);
    add_vec(1, 4'b1101, 1, 1, 4'b1111, 0, 0, 0);
    add_vec(1, 4'b1101, 1, 1, 4'b1101, 1, 1, 0);

    foreach (vecs[n]) begin
      drive(vecs[n].rst_n, vecs[n].req, vecs[n].frame, vecs[n].irdy);
      tick();
      check($sformatf("vec%0d_gnt", n), 8'(gnt_), 8'(vecs[n].gnt));
      check($sformatf("vec%0d_vld", n), 8'(owner_vld), 8'(vecs[n].vld));
      check($sformatf("vec%0d_terr", n), 8'(timeout_err), 8'(vecs[n].terr));
      if (vecs[n].vld) check($sformatf("vec%0d_owner", n), 8'(owner), 8'(vecs[n].own));
    end

    // unused grant to master 1 is revoked after exactly TMO cycles
    drive(1, 4'b1101, 1, 1);
    for (int k = 1; k < TMO; k++) begin
      tick();
      check("tmo_hold_gnt", 8'(gnt_), 8'(4'b1101));
      check("tmo_hold_terr", 8'(timeout_err), 8'd0);
    end
    drive(1, 4'b1001, 1, 1);
    tick();
    check("tmo_revoke_gnt", 8'(gnt_), 8'(4'b1111));
    check("tmo_pulse", 8'(timeout_err), 8'd1);
    tick();
    check("tmo_next_gnt", 8'(gnt_), 8'(4'b1011));
    check("tmo_next_owner", 8'(owner), 8'd2);
    check("tmo_pulse_end", 8'(timeout_err), 8'd0);

    // master 2 busy, pre-empted by master 1
    drive(1, 4'b1011, 0, 1);
    tick();
    check("busy_entry_gnt", 8'(gnt_), 8'(4'b1011));
    tick();
    check("busy_hold_gnt", 8'(gnt_), 8'(4'b1011));
    drive(1, 4'b1001, 0, 0);
    tick();
    check("preempt_gnt", 8'(gnt_), 8'(4'b1111));
    check("preempt_vld", 8'(owner_vld), 8'd1);
    check("preempt_owner", 8'(owner), 8'd2);
    drive(1, 4'b1001, 0, 1);
    tick();
    check("preempt_stay_gnt", 8'(gnt_), 8'(4'b1111));
    drive(1, 4'b1001, 1, 1);
    tick();
    check("preempt_idle_gnt", 8'(gnt_), 8'(4'b1111));
    check("preempt_idle_vld", 8'(owner_vld), 8'd0);
    tick();
    check("preempt_regrant", 8'(gnt_), 8'(4'b1101));
    check("preempt_regrant_owner", 8'(owner), 8'd1);

    // async reset in the middle of a transaction
    drive(1, 4'b1101, 0, 1);
    tick();
    check("rst_busy_gnt", 8'(gnt_), 8'(4'b1101));
    #2 reset_ = 1'b0;
    #1;
    check("rst_async_gnt", 8'(gnt_), 8'(4'b1111));
    check("rst_async_vld", 8'(owner_vld), 8'd0);
    tick();
    reset_ = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_midtx_gnt", 8'(gnt_), 8'(4'b1111));
      check("rst_midtx_vld", 8'(owner_vld), 8'd0);
    end
    drive(1, 4'b1101, 1, 1);
    tick();
    check("rst_after_gnt", 8'(gnt_), 8'(4'b1101));

    // randomized traffic against the model
    drive(0, 4'b1111, 1, 1);
    tick();
    tick();
    model_reset();
    rq = 4'b1111; fr = 1'b1; ir = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) begin
        int b;
        b = $urandom_range(N - 1);
        rq[b] = ~rq[b];
      end
      if (fr) begin
        if ($urandom_range(23) == 0) fr = 1'b0;
      end else if ($urandom_range(3) == 0) fr = 1'b1;
      ir = fr ? ($urandom_range(5) != 0) : 1'($urandom_range(1));
      drive(1, rq, fr, ir);
      model_edge(rq, fr, ir);
      tick();
      check("rnd_gnt", 8'(gnt_), 8'(exp_gnt));
      check("rnd_vld", 8'(owner_vld), 8'(m_vld));
      check("rnd_terr", 8'(timeout_err), 8'(m_terr));
      check("rnd_onehot", 8'($countones(~gnt_) <= 1), 8'd1);
      if (m_vld) check("rnd_owner", 8'(owner), 8'(m_owner));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
